ifetch_bus: RTL and testbench

- Instruction-fetch bus master sitting directly upstream of the fetch stage.
- Accepts the fetch stage's next-PC request (val + address) and issues a single-outstanding read on the instruction bus (cmd/rsp valid-ready channels).
- Returns the instruction word with a one-cycle "data ready" pulse.
- Handles PC redirects (flush) by discarding stale responses, and reports misaligned, bus-error and timeout faults.

---
 rtl/ifetch_bus_pkg.sv | 24 ++
 rtl/ifetch_wdt.sv | 38 +++
 rtl/ifetch_bus.sv | 141 ++++++++++++++
 tb/tb_ifetch_bus.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_bus_pkg.sv
// Shared types and defaults for the instruction-fetch bus master.
package ifetch_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_RSP  = 2'd2,
    ST_DROP = 2'd3
  } state_e;

  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
  localparam logic [1:0] CAUSE_BUSERR   = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'd3;

  localparam logic [31:0] DEF_RST_PC  = 32'h8000_0000;
  localparam int          DEF_TIMEOUT = 255;

  // A disabled timeout (0) still needs a legal one-bit counter.
  function automatic int cnt_width(input int t);
    return (t > 0) ? $clog2(t + 1) : 1;
  endfunction

endpackage

// File: rtl/ifetch_wdt.sv
// Response watchdog: counts enabled cycles from a clear, flags when the count hits TIMEOUT.
// Expired is a registered-count compare; TIMEOUT=0 never expires.
module ifetch_wdt
  import ifetch_bus_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW = cnt_width(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  assign o_expired = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT));

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en && !o_expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ifetch_bus.sv
// Single-outstanding instruction fetch master: request -> cmd -> rsp -> one-cycle ifu pulse (min 3 cycles).
// Holds cmd until accepted; flushes discard the in-flight response via DROP; faults pulse on o_fault.
module ifetch_bus
  import ifetch_bus_pkg::*;
#(
  parameter int          AW      = 32,
  parameter int          DW      = 32,
  parameter int          TIMEOUT = DEF_TIMEOUT,
  parameter logic [AW-1:0] RST_PC = AW'(DEF_RST_PC)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req_val,
  input  logic [AW-1:0] i_req_addr,
  input  logic          i_flush,
  output logic          o_rsp_rdy_ifu,
  output logic [DW-1:0] o_instr,
  output logic          o_busy,
  output logic          o_cmd_val,
  input  logic          i_cmd_rdy,
  output logic [AW-1:0] o_cmd_addr,
  input  logic          i_rsp_val,
  output logic          o_rsp_rdy,
  input  logic [DW-1:0] i_rsp_data,
  input  logic          i_rsp_err,
  output logic          o_fault,
  output logic [1:0]    o_fault_cause,
  output logic [AW-1:0] o_fault_addr
);

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          kill_q, kill_d;
  logic [DW-1:0] instr_q, instr_d;
  logic          ifu_q, ifu_d;
  logic          fault_q, fault_d;
  logic [1:0]    cause_q, cause_d;
  logic [AW-1:0] fault_addr_q, fault_addr_d;
  logic          wdt_expired;

  ifetch_wdt #(.TIMEOUT(TIMEOUT)) u_wdt (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (state_q != ST_RSP),
    .i_en      (state_q == ST_RSP),
    .o_expired (wdt_expired)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    kill_d       = kill_q;
    instr_d      = instr_q;
    ifu_d        = 1'b0;
    fault_d      = 1'b0;
    cause_d      = cause_q;
    fault_addr_d = fault_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (i_req_val && !i_flush) begin
          addr_d = i_req_addr;
          if (i_req_addr[1:0] != 2'b00) begin
            fault_d      = 1'b1;
            cause_d      = CAUSE_MISALIGN;
            fault_addr_d = i_req_addr;
          end else begin
            state_d = ST_CMD;
          end
        end
      end
      ST_CMD: begin
        // The command cannot be retracted, so a flush here only marks its response as stale.
        if (i_flush) kill_d = 1'b1;
        if (i_cmd_rdy) begin
          state_d = (kill_q || i_flush) ? ST_DROP : ST_RSP;
          kill_d  = 1'b0;
        end
      end
      ST_RSP: begin
        if (i_rsp_val) begin
          state_d = ST_IDLE;
          if (!i_flush) begin
            if (i_rsp_err) begin
              fault_d      = 1'b1;
              cause_d      = CAUSE_BUSERR;
              fault_addr_d = addr_q;
            end else begin
              instr_d = i_rsp_data;
              ifu_d   = 1'b1;
            end
          end
        end else if (i_flush) begin
          state_d = ST_DROP;
        end else if (wdt_expired) begin
          fault_d      = 1'b1;
          cause_d      = CAUSE_TIMEOUT;
          fault_addr_d = addr_q;
          state_d      = ST_DROP;
        end
      end
      ST_DROP: begin
        if (i_rsp_val) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= RST_PC;
      kill_q       <= 1'b0;
      instr_q      <= '0;
      ifu_q        <= 1'b0;
      fault_q      <= 1'b0;
      cause_q      <= CAUSE_NONE;
      fault_addr_q <= RST_PC;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      kill_q       <= kill_d;
      instr_q      <= instr_d;
      ifu_q        <= ifu_d;
      fault_q      <= fault_d;
      cause_q      <= cause_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  // A redirect in the pulse cycle cancels whatever event was about to be reported.
  assign o_rsp_rdy_ifu = ifu_q & ~i_flush;
  assign o_fault       = fault_q & ~i_flush;
  assign o_instr       = instr_q;
  assign o_fault_cause = cause_q;
  assign o_fault_addr  = fault_addr_q;
  assign o_busy        = (state_q != ST_IDLE);
  assign o_cmd_val     = (state_q == ST_CMD);
  assign o_cmd_addr    = addr_q;
  assign o_rsp_rdy     = (state_q == ST_RSP) || (state_q == ST_DROP);

endmodule

// File: tb/tb_ifetch_bus.sv
// Bench for ifetch_bus: vector table of fetch transactions driven through a bus model,
// with expected ifu/fault events queued at request time and matched when the DUT reports them.
module tb_ifetch_bus;
  import ifetch_bus_pkg::*;

  typedef enum logic [1:0] {EV_NONE, EV_PULSE, EV_FAULT} ev_e;

  typedef struct {
    logic [31:0] addr;
    int          cmd_wait;
    int          rsp_wait;
    logic [31:0] data;
    logic        err;
    logic        flush_cmd;
    logic        flush_rsp;
    logic        flush_pulse;
    ev_e         exp_ev;
    logic [1:0]  exp_cause;
    int          exp_lat;
  } vec_t;

  typedef struct {
    ev_e         ev;
    logic [31:0] data;
    logic [1:0]  cause;
    logic [31:0] addr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_val;
  logic [31:0] req_addr;
  logic        flush;
  logic        o_rsp_rdy_ifu;
  logic [31:0] o_instr;
  logic        o_busy;
  logic        o_cmd_val;
  logic        cmd_rdy;
  logic [31:0] o_cmd_addr;
  logic        rsp_val;
  logic        o_rsp_rdy;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        o_fault;
  logic [1:0]  o_fault_cause;
  logic [31:0] o_fault_addr;

  int   checks = 0;
  int   errs = 0;
  int   cyc = 0;
  int   evt_cnt = 0;
  int   last_evt_cyc = 0;
  int   req_cyc = 0;
  exp_t sb[$];
  exp_t me;
  vec_t vt[10];

  ifetch_bus #(.AW(32), .DW(32), .TIMEOUT(8), .RST_PC(32'h8000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_req_val     (req_val),
    .i_req_addr    (req_addr),
    .i_flush       (flush),
    .o_rsp_rdy_ifu (o_rsp_rdy_ifu),
    .o_instr       (o_instr),
    .o_busy        (o_busy),
    .o_cmd_val     (o_cmd_val),
    .i_cmd_rdy     (cmd_rdy),
    .o_cmd_addr    (o_cmd_addr),
    .i_rsp_val     (rsp_val),
    .o_rsp_rdy     (o_rsp_rdy),
    .i_rsp_data    (rsp_data),
    .i_rsp_err     (rsp_err),
    .o_fault       (o_fault),
    .o_fault_cause (o_fault_cause),
    .o_fault_addr  (o_fault_addr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [31:0] a, input int cw, input int rw, input logic [31:0] d,
                              input logic e, input logic fc, input logic fr, input logic fp,
                              input ev_e ev, input logic [1:0] c, input int lat);
    vec_t v;
    v.addr = a; v.cmd_wait = cw; v.rsp_wait = rw; v.data = d; v.err = e;
    v.flush_cmd = fc; v.flush_rsp = fr; v.flush_pulse = fp;
    v.exp_ev = ev; v.exp_cause = c; v.exp_lat = lat;
    return v;
  endfunction

  // Event monitor: every ifu pulse or fault must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_rsp_rdy_ifu && o_fault) begin
        checks++;
        errs++;
        $display("FAIL both_pulses: ifu=1 fault=1, required at most one");
      end
      if (o_rsp_rdy_ifu || o_fault) begin
        evt_cnt++;
        last_evt_cyc = cyc;
        if (sb.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL unexpected_event: ifu=%0b fault=%0b cause=%0d instr=%h, required none",
                   o_rsp_rdy_ifu, o_fault, o_fault_cause, o_instr);
        end else begin
          me = sb.pop_front();
          chk("evt_kind", 32'(o_fault ? EV_FAULT : EV_PULSE), 32'(me.ev));
          if (me.ev == EV_PULSE) begin
            chk("instr", o_instr, me.data);
          end else begin
            chk("fault_cause", 32'(o_fault_cause), 32'(me.cause));
            chk("fault_addr", o_fault_addr, me.addr);
          end
        end
      end
    end
  end

  task automatic check_reset_vals();
    chk("rst_cmd_val", 32'(o_cmd_val), 32'd0);
    chk("rst_ifu", 32'(o_rsp_rdy_ifu), 32'd0);
    chk("rst_instr", o_instr, 32'd0);
    chk("rst_fault", 32'(o_fault), 32'd0);
    chk("rst_cause", 32'(o_fault_cause), 32'd0);
    chk("rst_fault_addr", o_fault_addr, 32'h8000_0000);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_rsp_rdy", 32'(o_rsp_rdy), 32'd0);
  endtask

  task automatic run_txn(input vec_t v);
    int   ev0;
    exp_t e;
    ev0 = evt_cnt;
    if (v.exp_ev != EV_NONE) begin
      e.ev = v.exp_ev; e.data = v.data; e.cause = v.exp_cause; e.addr = v.addr;
      sb.push_back(e);
    end
    tick();
    req_val  = 1'b1;
    req_addr = v.addr;
    req_cyc  = cyc;
    if (v.addr[1:0] != 2'b00) begin
      for (int i = 0; i < 3; i++) begin
        tick();
        req_val = 1'b0;
        chk("misalign_no_cmd", 32'(o_cmd_val | o_busy), 32'd0);
      end
    end else begin
      for (int i = 0; i <= v.cmd_wait; i++) begin
        tick();
        req_val = 1'b0;
        cmd_rdy = (i == v.cmd_wait);
        flush   = v.flush_cmd && (i == 0);
        chk("cmd_val", 32'(o_cmd_val), 32'd1);
        chk("cmd_addr", o_cmd_addr, v.addr);
      end
      tick();
      cmd_rdy = 1'b0;
      flush   = 1'b0;
      for (int i = 0; i < v.rsp_wait; i++) begin
        flush = v.flush_rsp && (i == v.rsp_wait - 1);
        tick();
      end
      flush    = 1'b0;
      rsp_val  = 1'b1;
      rsp_data = v.data;
      rsp_err  = v.err;
      chk("rsp_rdy", 32'(o_rsp_rdy), 32'd1);
      tick();
      rsp_val = 1'b0;
      rsp_err = 1'b0;
      flush   = v.flush_pulse;
      tick();
      flush = 1'b0;
      for (int k = 0; k < 40 && o_busy; k++) tick();
      chk("idle_reached", 32'(o_busy), 32'd0);
    end
    tick();
    tick();
    chk("evt_count", 32'(evt_cnt - ev0), 32'(v.exp_ev != EV_NONE));
    if (v.exp_lat != 0) chk("latency", 32'(last_evt_cyc - req_cyc), 32'(v.exp_lat));
  endtask

  initial begin
    int ev0;
    rst = 1'b1; req_val = 1'b0; req_addr = '0; flush = 1'b0;
    cmd_rdy = 1'b0; rsp_val = 1'b0; rsp_data = '0; rsp_err = 1'b0;

    //        addr          cw rw data          err fc fr fp  event     cause lat
    vt[0] = mk(32'h8000_0000, 0, 0, 32'h0000_0013, 0, 0, 0, 0, EV_PULSE, 2'd0, 3);
    vt[1] = mk(32'h8000_0008, 4, 2, 32'hDEAD_BEEF, 0, 0, 0, 0, EV_PULSE, 2'd0, 9);
    vt[2] = mk(32'h8000_0004, 0, 2, 32'h1111_1111, 0, 0, 1, 0, EV_NONE,  2'd0, 0);
    vt[3] = mk(32'h8000_0100, 0, 1, 32'h2222_2222, 0, 0, 0, 0, EV_PULSE, 2'd0, 4);
    vt[4] = mk(32'h8000_0010, 3, 0, 32'h3333_3333, 0, 1, 0, 0, EV_NONE,  2'd0, 0);
    vt[5] = mk(32'h8000_0002, 0, 0, 32'h0,         0, 0, 0, 0, EV_FAULT, 2'd1, 1);
    vt[6] = mk(32'h8000_0020, 1, 1, 32'h4444_4444, 1, 0, 0, 0, EV_FAULT, 2'd2, 5);
    vt[7] = mk(32'h8000_0030, 0, 12, 32'h5555_5555, 0, 0, 0, 0, EV_FAULT, 2'd3, 11);
    vt[8] = mk(32'h8000_0040, 0, 0, 32'h6666_6666, 0, 0, 0, 1, EV_NONE,  2'd0, 0);
    vt[9] = mk(32'h8000_0043, 0, 0, 32'h0,         0, 0, 0, 0, EV_FAULT, 2'd1, 1);

    repeat (3) tick();
    check_reset_vals();
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_txn(vt[i]);

    // A flush in IDLE blocks the request sampled in the same cycle.
    ev0 = evt_cnt;
    tick();
    req_val = 1'b1; req_addr = 32'h8000_0050; flush = 1'b1;
    tick();
    req_val = 1'b0; flush = 1'b0;
    chk("flush_blocks_req", 32'(o_busy | o_cmd_val), 32'd0);
    tick();
    chk("flush_blocks_evt", 32'(evt_cnt - ev0), 32'd0);

    // Reset while waiting for a response.
    tick();
    req_val = 1'b1; req_addr = 32'h8000_0200;
    tick();
    req_val = 1'b0; cmd_rdy = 1'b1;
    tick();
    cmd_rdy = 1'b0;
    chk("pre_rst_in_rsp", 32'(o_rsp_rdy & o_busy), 32'd1);
    rst = 1'b1;
    tick();
    check_reset_vals();
    rst = 1'b0;
    run_txn(mk(32'h8000_0300, 1, 0, 32'h7777_7777, 0, 0, 0, 0, EV_PULSE, 2'd0, 4));

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "global timeout");
  end

endmodule
